// File: rtl/request_arbiter_pkg.sv
// arb_pkg: shared FSM state encodings and width helper for request_arbiter
package arb_pkg;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] GRANT = 2'b01;
  localparam logic [STATE_W-1:0] GAP   = 2'b10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/request_arbiter_if.sv
// request_arbiter_if: request/grant bundle between requesters (master) and arbiter (slave)
//   req      requester -> arbiter  level request per requester
//   grant    arbiter -> requester  registered one-hot grant
//   grant_id arbiter -> requester  current/last owner index
//   busy, state, timeout           status and debug
interface request_arbiter_if import arb_pkg::*; #(parameter int N = 4) ();
  localparam int W = clog2(N);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic busy;
  logic [STATE_W-1:0] state;
  logic timeout;
  modport master (output req, input grant, grant_id, busy, state, timeout);
  modport slave (input req, output grant, grant_id, busy, state, timeout);
endinterface

// File: rtl/request_arbiter_rr_pick.sv
// rr_pick: first set request bit at or after ptr, wrapping N-1 -> 0
//   req   requests to search
//   ptr   highest-priority index
//   found any request set
//   idx   selected index (ptr when none)
module rr_pick import arb_pkg::*; #(
  parameter int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = ptr;
    j = ptr;
    // scan from farthest to nearest so the nearest hit is written last
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/request_arbiter.sv
// request_arbiter: round-robin arbiter with registered one-hot grant and one-cycle gap
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    request_arbiter_if.slave (req in; grant, grant_id, busy, state, timeout out)
//   REQUEST_ARBITER_TIMEOUT_EN: when defined, revokes grants held MAX_HOLD cycles
module request_arbiter import arb_pkg::*; #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic reset,
  request_arbiter_if.slave bus
);
  localparam int W = clog2(N);
  if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_bad_param
    $error("request_arbiter: N must be 2..8 and MAX_HOLD >= 1");
  end
  logic [STATE_W-1:0] state_q;
  logic [N-1:0] grant_q, cand;
  logic [W-1:0] id_q, ptr_q, pick_idx, next_ptr;
  logic busy_q, timeout_q, found, release_c, revoke;
`ifdef REQUEST_ARBITER_TIMEOUT_EN
  localparam int CW = clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_q;
  logic [N-1:0] blk_q;
  // a revoked owner stays masked until its request is seen low once
  assign cand = bus.req & ~blk_q;
  assign revoke = state_q == GRANT && bus.req[id_q] && hold_q == CW'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hold_q <= '0;
      blk_q <= '0;
    end else begin
      hold_q <= state_q == GRANT ? hold_q + 1'b1 : '0;
      blk_q <= (blk_q & bus.req) | (revoke ? grant_q : '0);
    end
`else
  assign cand = bus.req;
  assign revoke = 1'b0;
`endif
  assign release_c = state_q == GRANT && !bus.req[id_q];
  assign next_ptr = id_q == W'(N - 1) ? '0 : id_q + 1'b1;
  rr_pick #(.N(N)) u_pick (.req(cand), .ptr(ptr_q), .found(found), .idx(pick_idx));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= revoke;
      if (state_q == GRANT) begin
        if (release_c || revoke) begin
          state_q <= GAP;
          grant_q <= '0;
          busy_q <= 1'b0;
          ptr_q <= next_ptr;
        end
      end else if (found) begin
        state_q <= GRANT;
        grant_q <= N'(1) << pick_idx;
        id_q <= pick_idx;
        busy_q <= 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  assign bus.grant = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy = busy_q;
  assign bus.state = state_q;
  assign bus.timeout = timeout_q;
endmodule
